// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, models the multi-cycle
// busy window of MULT/DIV and requests pipeline stalls while the unit is occupied.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILOout,
  output logic        o_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Handshake: an op is taken on a rising edge when start=1, Req=0, busy=0 and op
  // decodes to a real MDU op; otherwise it is dropped and the issuer must hold it
  // while stall=1.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [31:0]    r_hi, r_lo, w_hi_nx, w_lo_nx;
  logic [31:0]    r_pend_hi, r_pend_lo, w_pend_hi_nx, w_pend_lo_nx;
  logic           r_pend_we, w_pend_we_nx;

  logic           w_is_md, w_is_op, w_accept;
  logic [63:0]    w_smul, w_umul;
  logic [31:0]    w_a_abs, w_b_abs, w_dvd, w_dvs, w_uq, w_ur, w_quo, w_rem;
  logic           w_signed_div;

  assign w_is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign w_is_op  = (op >= OP_MULT) && (op <= OP_MTLO);
  assign busy     = (r_state == S_RUN);
  assign w_accept = start & ~Req & ~busy & w_is_op;

  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both DIV and DIVU; signs are restored afterwards
  // so the quotient truncates toward zero and the remainder follows A.
  assign w_signed_div = (op == OP_DIV);
  assign w_a_abs = A[31] ? (32'd0 - A) : A;
  assign w_b_abs = B[31] ? (32'd0 - B) : B;
  assign w_dvd   = w_signed_div ? w_a_abs : A;
  assign w_dvs   = w_signed_div ? w_b_abs : B;
  assign w_uq    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
  assign w_ur    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
  assign w_quo   = (w_signed_div && (A[31] ^ B[31])) ? (32'd0 - w_uq) : w_uq;
  assign w_rem   = (w_signed_div && A[31]) ? (32'd0 - w_ur) : w_ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
      r_pend_we <= w_pend_we_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    w_pend_we_nx = r_pend_we;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_pend_hi_nx = (op == OP_MULT) ? w_smul[63:32] : w_umul[63:32];
              w_pend_lo_nx = (op == OP_MULT) ? w_smul[31:0]  : w_umul[31:0];
              w_pend_we_nx = 1'b1;
              w_cnt_nx     = MULT_N;
              w_state_nx   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_pend_hi_nx = w_rem;
              w_pend_lo_nx = w_quo;
              // A zero divisor still occupies the unit but leaves HI/LO alone.
              w_pend_we_nx = (B != 32'd0);
              w_cnt_nx     = DIV_N;
              w_state_nx   = S_RUN;
            end
            OP_MTHI: w_hi_nx = A;
            OP_MTLO: w_lo_nx = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          if (r_pend_we) begin
            w_hi_nx = r_pend_hi;
            w_lo_nx = r_pend_lo;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign stall   = busy | (start & ~Req & w_is_md) | (start & busy & w_is_op);
  assign HI      = r_hi;
  assign LO      = r_lo;
  assign HILOout = (op == OP_MFHI) ? r_hi : ((op == OP_MFLO) ? r_lo : 32'd0);
  assign o_state = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: completions are checked by a monitor against a
// queue of hand-computed HI/LO results and busy lengths.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset, Req, start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall, o_state;
  logic [31:0] HI, LO, HILOout;

  logic [63:0] exp_q[$];
  int          len_q[$];
  int          total = 0;
  int          bad = 0;
  int          run_cnt = 0;
  logic        prev_busy = 1'b0;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Req(Req), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .stall(stall), .HI(HI), .LO(LO), .HILOout(HILOout), .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_q.push_back({hi, lo});
    len_q.push_back(len);
  endtask

  // Called just after a rising edge; presents one op for exactly one edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, input logic exp_stall);
    start = 1'b1; op = o; A = a; B = b; Req = rq;
    #1;
    chk("issue_stall", {63'd0, stall}, {63'd0, exp_stall});
    @(posedge clk); #1;
    start = 1'b0; op = NONE; Req = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("busy_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: a busy fall outside reset is a completion and must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      run_cnt   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          chk("hilo_result", {HI, LO}, exp_q.pop_front());
          chk("busy_len", 64'(run_cnt), 64'(len_q.pop_front()));
        end
        run_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    reset = 1'b0; Req = 1'b0; start = 1'b0; op = NONE; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_busy", {62'd0, busy, stall}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    wait_idle();
    start = 1'b1; op = MFHI;
    #1;
    chk("mfhi_out", {32'd0, HILOout}, {32'd0, 32'hFFFF_FFFF});
    chk("mfhi_nostall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; op = NONE;

    expect_op(32'd2, 32'd3, 10);
    issue(DIVU, 32'd17, 32'd5, 1'b0, 1'b1);
    wait_idle();

    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_idle();

    expect_op(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = MFLO;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("mflo_stall_busy", {63'd0, stall}, 64'd1);
    end
    chk("mflo_unstall", {63'd0, stall}, 64'd0);
    chk("mflo_out", {32'd0, HILOout}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; op = NONE;

    start = 1'b1; op = MTHI; A = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi", {32'd0, HI}, {32'd0, 32'h1234_5678});
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    op = MTLO; A = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    chk("mtlo", {HI, LO}, {32'h1234_5678, 32'h9ABC_DEF0});
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; op = NONE;

    expect_op(32'h1234_5678, 32'h9ABC_DEF0, 10);
    issue(DIV, 32'd55, 32'd0, 1'b0, 1'b1);
    wait_idle();

    issue(MULT, 32'd5, 32'd7, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("req_drop_busy", {63'd0, busy}, 64'd0);
    end
    chk("req_drop_hilo", {HI, LO}, {32'h1234_5678, 32'h9ABC_DEF0});
    @(posedge clk); #1;

    expect_op(32'd2, 32'd14, 10);
    issue(DIV, 32'd100, 32'd7, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    Req = 1'b1; start = 1'b1; op = MULT; A = 32'd9; B = 32'd9;
    #1;
    chk("req_in_run_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    Req = 1'b0; start = 1'b0; op = NONE;
    wait_idle();

    expect_op(32'd0, 32'h8000_0000, 10);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_idle();

    issue(DIVU, 32'd17, 32'd5, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    chk("async_reset_hilo", {HI, LO}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_busy", {63'd0, busy}, 64'd0);
    chk("post_reset_hilo", {HI, LO}, 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller owning the HI/LO register pair.
- Sits in the E stage. Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, sequences the busy period, and raises a stall request to the hazard unit.
- Supplies HILOout, which the pipeline carries forward to the M/W stages.
- Suppresses new operations when an exception flush (Req) is taken.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Req  input  1  exception/interrupt flush; E-stage op is discarded this cycle
- start  input  1  E-stage instruction is a valid MDU op this cycle
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NONE
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  multi-cycle operation in progress
- stall  output  1  hold F/D/E stages (combinational)
- HI  output  32  HI register
- LO  output  32  LO register
- HILOout  output  32  MFHI→HI, MFLO→LO, else 0 (combinational)

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=LO=0, busy=0, state=IDLE, counter=0, pending results=0.
- accept = start & ~Req & ~busy & (op != NONE).
- States:
  - IDLE: on accept with MULT/MULTU/DIV/DIVU:
    - latch the op's result into pending HI/LO.
    - load counter with MULT_CYCLES or DIV_CYCLES.
    - go to RUN; busy=1 from the next cycle.
  - RUN: busy=1, counter decrements each edge.
    - On the edge where counter==1: HI/LO ← pending, busy→0, state→IDLE.
    - busy is high for exactly N cycles.
    - New HI/LO are visible in the first cycle busy=0.
- MTHI/MTLO on accept: HI (resp. LO) ← A at that edge, single cycle, no busy.
- MFHI/MFLO: no state change. HILOout reflects the current HI/LO combinationally.
- stall = busy | (start & ~Req & op in {MULT,MULTU,DIV,DIVU}) | (start & busy & op != NONE).
  - Any MDU op behind a busy unit stalls.
  - The starting op's own stall is asserted only in its issue cycle.
- Arithmetic:
  - MULT: signed 32x32→64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of A.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - B=0 (DIV/DIVU): full DIV_CYCLES elapse, HI/LO unchanged.
- Boundaries:
  - start while busy: ignored, no restart, stall held.
  - Req with start in same cycle: op discarded, nothing latched, HI/LO unchanged.
  - Req during RUN: does not cancel; the op committed at issue completes normally.
  - MTHI/MTLO are never accepted while busy (they stall).
  - Reset mid-RUN: abort immediately to reset values; pending result lost.
  - The op/A/B values after issue do not affect the in-flight result.

Test Plan:
- reset low, then high; MULT A=0xFFFFFFFE(-2) B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI gives HILOout=0xFFFFFFFF.
- DIVU A=17 B=5 -> busy exactly 10 cycles, then LO=3, HI=2. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF; MFLO issued 2 cycles later -> stall=1 until busy falls; HI=0xFFFFFFFE, LO=0x00000001; HILOout=1 once unstalled.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 in consecutive cycles -> HI/LO updated at each edge, busy never asserts; DIV B=0 -> 10 busy cycles, HI/LO unchanged.
- start=1 op=MULT with Req=1 -> busy stays 0, HI/LO unchanged. Req=1 during DIV RUN -> result still written at cycle 10.
- reset asserted at RUN cycle 3 of DIVU -> busy=0, HI=LO=0 immediately (asynchronous); no late write after release.
